// File: rtl/alu_issue_ctrl_if.sv
// rtl/alu_issue_ctrl_if.sv - instruction and result handshake bundle for alu_issue_ctrl (ALU_ISSUE_ZFLAG_EN adds res_zero)
interface alu_issue_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic        res_valid;
    logic        res_ready;
    logic [7:0]  res_data;
    logic [1:0]  res_rd;
    logic        res_cout;
`ifdef ALU_ISSUE_ZFLAG_EN
    logic        res_zero;

    modport master (
        output in_valid, in_instr, res_ready,
        input  in_ready, res_valid, res_data, res_rd, res_cout, res_zero
    );
    modport slave (
        input  in_valid, in_instr, res_ready,
        output in_ready, res_valid, res_data, res_rd, res_cout, res_zero
    );
`else
    modport master (
        output in_valid, in_instr, res_ready,
        input  in_ready, res_valid, res_data, res_rd, res_cout
    );
    modport slave (
        input  in_valid, in_instr, res_ready,
        output in_ready, res_valid, res_data, res_rd, res_cout
    );
`endif
endinterface

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - issue/writeback controller driving one alu8 (optional zero flag: ALU_ISSUE_ZFLAG_EN)
module alu_issue_ctrl #(
    parameter logic [7:0] REG_INIT = 8'h00
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_issue_ctrl_if.slave  bus,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [2:0]       alu_f,
    input  logic [7:0]       alu_q,
    input  logic             alu_cout,
    output logic             carry_flag
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state_q, state_d;
    logic [15:0] instr_q, instr_d;
    logic [7:0]  rf_q [4];
    logic [7:0]  rf_d [4];
    logic        carry_q, carry_d;
    logic [7:0]  res_data_q, res_data_d;
    logic [1:0]  res_rd_q, res_rd_d;
    logic        res_cout_q, res_cout_d;
    logic [7:0]  wb_val;
    logic        wb_carry;

    logic [2:0] f_op;
    logic       ldi;
    logic [1:0] rd, rs1, rs2;
    logic [7:0] imm;

    assign f_op = instr_q[15:13];
    assign ldi  = instr_q[12];
    assign rd   = instr_q[11:10];
    assign rs1  = instr_q[9:8];
    assign rs2  = instr_q[7:6];
    assign imm  = instr_q[7:0];

`ifdef ALU_ISSUE_ZFLAG_EN
    logic zero_q, zero_d;
    assign bus.res_zero = zero_q;
`endif

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        rf_d       = rf_q;
        carry_d    = carry_q;
        res_data_d = res_data_q;
        res_rd_d   = res_rd_q;
        res_cout_d = res_cout_q;
`ifdef ALU_ISSUE_ZFLAG_EN
        zero_d     = zero_q;
`endif
        alu_a      = 8'h00;
        alu_b      = 8'h00;
        alu_f      = 3'b000;
        wb_val     = alu_q;
        wb_carry   = alu_cout;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    instr_d = bus.in_instr;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                alu_a = rf_q[rs1];
                alu_b = rf_q[rs2];
                alu_f = f_op;
                // LDI keeps the architectural carry; the ALU result is dropped
                if (ldi) begin
                    wb_val   = imm;
                    wb_carry = carry_q;
                end
                rf_d[rd]   = wb_val;
                carry_d    = wb_carry;
                res_data_d = wb_val;
                res_rd_d   = rd;
                res_cout_d = wb_carry;
`ifdef ALU_ISSUE_ZFLAG_EN
                zero_d     = (wb_val == 8'h00);
`endif
                state_d    = RESP;
            end
            RESP: begin
                if (bus.res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            instr_q    <= 16'h0000;
            for (int i = 0; i < 4; i++) rf_q[i] <= REG_INIT;
            carry_q    <= 1'b0;
            res_data_q <= 8'h00;
            res_rd_q   <= 2'd0;
            res_cout_q <= 1'b0;
`ifdef ALU_ISSUE_ZFLAG_EN
            zero_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            rf_q       <= rf_d;
            carry_q    <= carry_d;
            res_data_q <= res_data_d;
            res_rd_q   <= res_rd_d;
            res_cout_q <= res_cout_d;
`ifdef ALU_ISSUE_ZFLAG_EN
            zero_q     <= zero_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.res_valid = (state_q == RESP);
    assign bus.res_data  = res_data_q;
    assign bus.res_rd    = res_rd_q;
    assign bus.res_cout  = res_cout_q;
    assign carry_flag    = carry_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - self-checking bench for alu_issue_ctrl with alu8 model and reference model
module tb_alu_issue_ctrl;
    localparam logic [7:0] RI = 8'h3C;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] alu_a, alu_b, alu_q;
    logic [2:0] alu_f;
    logic       alu_cout;
    logic       carry_flag;
    logic [8:0] alu_out;
    int         n_checks = 0;
    int         n_err = 0;
    bit         chk_en = 1'b0;

    alu_issue_ctrl_if bus();

    alu_issue_ctrl #(.REG_INIT(RI)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
        .alu_q(alu_q), .alu_cout(alu_cout), .carry_flag(carry_flag)
    );

    always #5 clk = ~clk;

    // {cout, q} of the 8-bit ALU
    function automatic logic [8:0] alu8(input logic [7:0] a, input logic [7:0] b, input logic [2:0] f);
        case (f)
            3'd0: return {1'b0, a} + {1'b0, b};
            3'd1: return {(a < b), a - b};
            3'd2: return {1'b0, a | b};
            3'd3: return {1'b0, a & b};
            3'd4: return {1'b0, a ^ b};
            3'd5: return {1'b0, ~a};
            3'd6: return {1'b0, a[6:0], 1'b0};
            default: return {1'b0, a[7], a[7:1]};
        endcase
    endfunction

    assign alu_out  = alu8(alu_a, alu_b, alu_f);
    assign alu_q    = alu_out[7:0];
    assign alu_cout = alu_out[8];

    function automatic logic [15:0] ldi(input logic [1:0] rd, input logic [7:0] imm);
        return {3'b000, 1'b1, rd, 2'b00, imm};
    endfunction

    function automatic logic [15:0] op(input logic [2:0] f, input logic [1:0] rd, input logic [1:0] rs1, input logic [1:0] rs2);
        return {f, 1'b0, rd, rs1, rs2, 6'b000000};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_checks++;
        n_err++;
        $display("FAIL %s: got timeout expected event", nm);
    endtask

    // Reference model: phase 0 waiting, 1 executing, 2 holding a result
    int         m_phase;
    logic [15:0] m_ins;
    logic [7:0] m_rf [4];
    logic       m_carry;
    logic [7:0] m_data;
    logic [1:0] m_rd;
    logic       m_cout;
    logic       m_zero;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            m_ins   = 16'h0;
            for (int i = 0; i < 4; i++) m_rf[i] = RI;
            m_carry = 1'b0;
            m_data  = 8'h00;
            m_rd    = 2'd0;
            m_cout  = 1'b0;
            m_zero  = 1'b0;
        end else begin
            case (m_phase)
                0: if (bus.in_valid) begin
                    m_ins   = bus.in_instr;
                    m_phase = 1;
                end
                1: begin
                    logic [8:0] r;
                    r = alu8(m_rf[m_ins[9:8]], m_rf[m_ins[7:6]], m_ins[15:13]);
                    if (m_ins[12]) r = {m_carry, m_ins[7:0]};
                    m_rf[m_ins[11:10]] = r[7:0];
                    m_carry = r[8];
                    m_data  = r[7:0];
                    m_rd    = m_ins[11:10];
                    m_cout  = r[8];
                    m_zero  = (r[7:0] == 8'h00);
                    m_phase = 2;
                end
                default: if (bus.res_ready) m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", bus.in_ready, m_phase == 0);
            check("res_valid", bus.res_valid, m_phase == 2);
            check("carry_flag", carry_flag, m_carry);
            check("res_data", bus.res_data, m_data);
            check("res_rd", bus.res_rd, m_rd);
            check("res_cout", bus.res_cout, m_cout);
`ifdef ALU_ISSUE_ZFLAG_EN
            check("res_zero", bus.res_zero, m_zero);
`endif
            check("alu_a", alu_a, (m_phase == 1) ? m_rf[m_ins[9:8]] : 8'h00);
            check("alu_b", alu_b, (m_phase == 1) ? m_rf[m_ins[7:6]] : 8'h00);
            check("alu_f", alu_f, (m_phase == 1) ? m_ins[15:13] : 3'd0);
        end
    end

    // Issue one instruction and check the literal result; hold>0 stalls res_ready
    task automatic issue(input string nm, input logic [15:0] ins, input logic [7:0] ed,
                         input logic [1:0] erd, input logic ec, input int hold);
        int k;
        @(posedge clk); #1;
        bus.in_valid  = 1'b1;
        bus.in_instr  = ins;
        bus.res_ready = (hold == 0);
        k = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            k++;
            if (k > 20) break;
        end
        if (k > 20) begin
            timeout({nm, "_accept"});
            return;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        k = 0;
        forever begin
            @(negedge clk);
            k++;
            if (bus.res_valid || k >= 10) break;
        end
        check({nm, "_latency"}, k, 2);
        check({nm, "_data"}, bus.res_data, ed);
        check({nm, "_rd"}, bus.res_rd, erd);
        check({nm, "_cout"}, bus.res_cout, ec);
        if (hold > 0) begin
            @(posedge clk); #1;
            bus.in_valid = 1'b1;
            bus.in_instr = ldi(2'd3, 8'h00);
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check({nm, "_hold_valid"}, bus.res_valid, 1);
                check({nm, "_hold_data"}, bus.res_data, ed);
                check({nm, "_hold_rd"}, bus.res_rd, erd);
                check({nm, "_hold_in_ready"}, bus.in_ready, 0);
            end
            @(posedge clk); #1;
            bus.in_valid  = 1'b0;
            bus.res_ready = 1'b1;
        end
        @(posedge clk); #1;
        check({nm, "_released"}, bus.res_valid, 0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_instr  = 16'h0;
        bus.res_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_res_data", bus.res_data, 0);
        check("rst_carry", carry_flag, 0);

        issue("ldi_r0", ldi(2'd0, 8'h7F), 8'h7F, 2'd0, 1'b0, 0);
        issue("ldi_r1", ldi(2'd1, 8'h01), 8'h01, 2'd1, 1'b0, 0);
        issue("add_80", op(3'd0, 2'd2, 2'd0, 2'd1), 8'h80, 2'd2, 1'b0, 0);
        issue("ldi_r3", ldi(2'd3, 8'hFF), 8'hFF, 2'd3, 1'b0, 0);
        issue("add_carry", op(3'd0, 2'd2, 2'd3, 2'd1), 8'h00, 2'd2, 1'b1, 0);
        issue("sub_borrow", op(3'd1, 2'd0, 2'd1, 2'd3), 8'h02, 2'd0, 1'b1, 0);
        issue("ldi_keeps_c", ldi(2'd0, 8'h80), 8'h80, 2'd0, 1'b1, 0);
        issue("sra", op(3'd7, 2'd1, 2'd0, 2'd2), 8'hC0, 2'd1, 1'b0, 0);
        check("sra_carry_clr", carry_flag, 0);
        issue("sla", op(3'd6, 2'd1, 2'd1, 2'd0), 8'h80, 2'd1, 1'b0, 0);
        issue("not", op(3'd5, 2'd2, 2'd1, 2'd3), 8'h7F, 2'd2, 1'b0, 0);
        issue("bp_add", op(3'd0, 2'd2, 2'd0, 2'd1), 8'h00, 2'd2, 1'b1, 5);
        issue("bp_r3_kept", op(3'd2, 2'd3, 2'd3, 2'd3), 8'hFF, 2'd3, 1'b0, 0);
        issue("ldi_r1_05", ldi(2'd1, 8'h05), 8'h05, 2'd1, 1'b0, 0);
        issue("xor_alias", op(3'd4, 2'd1, 2'd1, 2'd1), 8'h00, 2'd1, 1'b0, 0);
        issue("ldi_r2_55", ldi(2'd2, 8'h55), 8'h55, 2'd2, 1'b0, 0);
        issue("add_carry2", op(3'd0, 2'd3, 2'd3, 2'd3), 8'hFE, 2'd3, 1'b1, 0);

        // Reset during EXEC of ADD r2
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_instr = op(3'd0, 2'd2, 2'd0, 2'd3);
        begin
            int k;
            k = 0;
            while (!bus.in_ready && k < 20) begin
                @(negedge clk);
                k++;
            end
            if (k >= 20) timeout("rst_accept");
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_exec_in_ready", bus.in_ready, 1);
        check("rst_exec_res_valid", bus.res_valid, 0);
        check("rst_exec_carry", carry_flag, 0);
        check("rst_exec_alu_a", alu_a, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        issue("r2_after_rst", op(3'd2, 2'd2, 2'd2, 2'd2), RI, 2'd2, 1'b0, 0);

        // Randomized traffic against the reference model
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            bus.in_valid  = ($urandom_range(0, 1) == 1);
            bus.in_instr  = 16'($urandom);
            bus.in_instr[12] = ($urandom_range(0, 2) == 0);
            bus.res_ready = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 149) != 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        bus.res_ready = 1'b1;
        repeat (4) @(posedge clk);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Issue/writeback controller that drives the 8-bit ALU (`alu8`) as its initiator. It accepts 16-bit instruction words over a valid/ready handshake and reads operands from a 4-entry, 8-bit register file. It drives A/B/F to the ALU, captures Q/Cout, writes the result back, and reports each result over a second valid/ready handshake. It sits between an instruction source (testbench or small program ROM) and one `alu8` instance.

## Interface
- `REG_INIT`, default 8'h00: reset value of every register file entry.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  instruction present.
- `in_ready`  out  1  controller can accept an instruction.
- `in_instr`  in  16  instruction fields:
  - [15:13] F opcode (alu8 encoding: 000 ADD, 001 SUB, 010 OR, 011 AND, 100 XOR, 101 NOT, 110 SLA, 111 SRA)
  - [12] LDI
  - [11:10] rd
  - [9:8] rs1
  - [7:6] rs2
  - [7:0] imm, used only when LDI=1
- `alu_a`, `alu_b`  out  8 each  operands to alu8.
- `alu_f`  out  3  opcode to alu8.
- `alu_q`  in  8  ALU result (combinational).
- `alu_cout`  in  1  ALU carry/borrow.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts result.
- `res_data`  out  8  written-back value.
- `res_rd`  out  2  destination register.
- `res_cout`  out  1  carry flag after this instruction.
- `carry_flag`  out  1  architectural carry flag.

## Operation
- FSM has three states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: latch `in_instr`, go to EXEC.
- EXEC (exactly one cycle):
  - Drive `alu_a`=rf[rs1], `alu_b`=rf[rs2], `alu_f`=F.
  - At the closing edge:
    - LDI=0: rf[rd]<=`alu_q`; `carry_flag`<=`alu_cout`.
    - LDI=1: rf[rd]<=imm; `carry_flag` unchanged; ALU result discarded.
  - At the same edge, capture `res_data`, `res_rd` and `res_cout` (the new `carry_flag`), then go to RESP.
- RESP:
  - `res_valid`=1. Outputs stay stable until `res_valid`&&`res_ready`; on that edge go to IDLE.
- Outside EXEC, `alu_a`, `alu_b` and `alu_f` are driven 0.
- rd may equal rs1 or rs2. Operands are read before writeback, so the old value is used.
- NOT, SLA and SRA ignore `alu_b`; the controller still drives rf[rs2].
- Logic and shift ops clear `carry_flag`, because alu8 returns Cout=0 for them.
- `in_ready`=0 in EXEC and RESP. `in_valid` is ignored there and the instruction is not consumed.
- Reset values:
  - `in_ready`=1 after reset release.
  - `res_valid`=0, `res_data`=0, `res_rd`=0, `res_cout`=0, `carry_flag`=0.
  - All rf entries = `REG_INIT`.
  - ALU outputs = 0.
- Reset asserted mid-EXEC or mid-RESP aborts the instruction with no writeback, returns to IDLE and restores all reset values.

## Timing
- Accept edge is T. EXEC runs in cycle T+1. Writeback and capture happen at edge T+2. `res_valid` is high from cycle T+2.
- With `res_ready` held high: `res_valid` lasts 1 cycle, `in_ready` returns in cycle T+3. Peak throughput is one instruction per 3 cycles.
- A back-to-back dependent instruction reads the updated register, since writeback completes before the next accept.
- `in_ready` and `res_valid` are registered state decodes with no combinational path from `in_valid` or `res_ready`.

## Configuration
- `ALU_ISSUE_ZFLAG_EN` defined:
  - Adds output `res_zero` (1 bit) and an internal zero flag, set when the written value == 8'h00. LDI updates it too.
  - `res_zero` is captured with `res_data` and resets to 0.
- Not defined: port and logic are absent. All other behaviour is identical.

## Test plan
- Setup: LDI r0=0x7F, then LDI r1=0x01. Then ADD r2=r0+r1 -> `res_data`=0x80, `res_cout`=0, `res_rd`=2, `res_valid` exactly 2 cycles after accept.
- Carry/borrow: LDI r3=0xFF.
  - ADD r2=r3+r1 -> 0x00, `res_cout`=1 (`res_zero`=1 if enabled).
  - SUB r0=r1-r3 -> 0x02, `res_cout`=1.
- Flags on logic/shift: LDI r0=0x80; SRA r1=r0 -> 0xC0, `carry_flag` cleared to 0. Then SLA r1=r1 -> 0x80. Then NOT r2=r1 -> 0x7F.
- Backpressure: hold `res_ready`=0 for 5 cycles after ADD completes -> `res_valid`, `res_data` and `res_rd` are stable and `in_ready`=0. A new `in_valid` in that window is not consumed.
- Aliasing: with r1=0x05, XOR r1=r1^r1 -> 0x00 written to r1, using the pre-write operand.
- Reset: assert `rst_n`=0 during EXEC of ADD r2 -> r2 stays `REG_INIT` after release, `res_valid`=0, `in_ready`=1, `carry_flag`=0.
